snake_dir_ctrl: RTL and testbench

SNAKE_DIR_CTRL -- requirements
Module: snake_dir_ctrl

---
 rtl/snake_dir_ctrl.sv | 109 ++++++++++
 tb/tb_snake_dir_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl: direction and step-timing controller for a snake game.
//   Raw push-buttons are synchronised, debounced per bit and decoded into a
//   requested direction. A free-running step timer (frozen while paused)
//   produces a one-cycle tick. On each step the requested direction is
//   committed unless it would reverse the snake onto itself.
// Ports:
//   clk         - single clock, rising edge
//   rst         - synchronous, active-low reset
//   button[2:0] - raw asynchronous push-buttons
//   pause       - freezes the step timer while high
//   tick        - one-cycle game-step strobe
//   dir[1:0]    - committed movement direction
//   dir_changed - one-cycle pulse when dir takes a new value
//   rev_blocked - one-cycle pulse when a reversal request is rejected
module snake_dir_ctrl #(
  parameter int DEB_LEN  = 250000,
  parameter int TICK_DIV = 33554432
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] button,
  input  logic       pause,
  output logic       tick,
  output logic [1:0] dir,
  output logic       dir_changed,
  output logic       rev_blocked
);

  localparam int DW = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;
  localparam logic [DW-1:0] DEB_MAX = DW'(DEB_LEN - 1);
  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] STEP_MAX = TW'(TICK_DIV - 1);

  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    deb;
  logic [DW-1:0] deb_cnt [3];
  logic [TW-1:0] step_cnt;
  logic          step;
  logic [1:0]    req;
  logic [1:0]    rev_dir;

  // Synchroniser and per-bit debounce. A bit flips only after its
  // synchronised value has disagreed for DEB_LEN consecutive edges.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1 <= 3'b101;
      sync2 <= 3'b101;
      deb   <= 3'b101;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_MAX) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    req = 2'b00;
    if (!deb[2])                req = 2'b10;
    else if (deb[1:0] == 2'b01) req = 2'b11;
    else if (deb[1:0] == 2'b10) req = 2'b01;
    else                        req = 2'b00;
  end

  // Reversal pairs are 00<->10 and 01<->11: flip the MSB, keep the LSB.
  assign rev_dir = {~dir[1], dir[0]};
  assign step    = (step_cnt == STEP_MAX) && !pause;

  // Step timer and direction commit. dir is loaded on the same edge that
  // raises tick, so it is already valid in the tick cycle. req comes from
  // the pre-edge debounced bits, so a coincident debounce update waits for
  // the following step.
  always_ff @(posedge clk) begin
    if (!rst) begin
      step_cnt    <= '0;
      tick        <= 1'b0;
      dir         <= 2'b11;
      dir_changed <= 1'b0;
      rev_blocked <= 1'b0;
    end else begin
      tick        <= step;
      dir_changed <= 1'b0;
      rev_blocked <= 1'b0;
      if (!pause) begin
        if (step) step_cnt <= '0;
        else      step_cnt <= step_cnt + 1'b1;
      end
      if (step) begin
        if (req == rev_dir) begin
          rev_blocked <= 1'b1;
        end else if (req != dir) begin
          dir         <= req;
          dir_changed <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Self-checking bench for snake_dir_ctrl with DEB_LEN=4, TICK_DIV=8.
// Each table row is a segment of constant inputs held for n edges, with the
// expected tick count, pulse counts, edge of first tick (1-based, 0 = none)
// and final dir worked out by hand from the edge timeline.
module tb_snake_dir_ctrl;

  logic       clk;
  logic       rst;
  logic [2:0] button;
  logic       pause;
  logic       tick;
  logic [1:0] dir;
  logic       dir_changed;
  logic       rev_blocked;

  snake_dir_ctrl #(.DEB_LEN(4), .TICK_DIV(8)) dut (
    .clk(clk),
    .rst(rst),
    .button(button),
    .pause(pause),
    .tick(tick),
    .dir(dir),
    .dir_changed(dir_changed),
    .rev_blocked(rev_blocked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic [2:0] btn;
    logic       pse;
    int         n;
    logic [1:0] e_dir;
    int         e_ticks;
    int         e_chg;
    int         e_blk;
    int         e_first;
  } vec_t;

  localparam int NV = 23;
  vec_t tbl [NV];
  vec_t sbq [$];

  int compared   = 0;
  int mismatched = 0;
  logic [1:0] prev_dir;
  logic       have_prev = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_cycles(input int n, input logic r,
                            output int ticks, output int chg,
                            output int blk, output int first);
    ticks = 0; chg = 0; blk = 0; first = 0;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      #1;
      if (tick) begin
        ticks++;
        if (first == 0) first = k;
      end
      if (dir_changed) chg++;
      if (rev_blocked) blk++;
      if (r) begin
        check("excl_pulses", int'(dir_changed & rev_blocked), 0);
        if (have_prev) check("dir_only_on_tick", int'((dir != prev_dir) && !tick), 0);
      end
      prev_dir  = dir;
      have_prev = 1'b1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   t, c, b, f;
    int   edges;
    vec_t e;

    //           r     btn     pse  n   dir   tk chg blk first
    tbl[0]  = '{1'b0, 3'b101, 1'b0, 2, 2'b11, 0, 0, 0, 0};
    tbl[1]  = '{1'b1, 3'b101, 1'b0, 16, 2'b11, 2, 0, 0, 8};
    tbl[2]  = '{1'b1, 3'b110, 1'b0, 8, 2'b11, 1, 0, 1, 8};
    tbl[3]  = '{1'b1, 3'b000, 1'b0, 8, 2'b10, 1, 1, 0, 8};
    tbl[4]  = '{1'b1, 3'b101, 1'b0, 8, 2'b11, 1, 1, 0, 8};
    tbl[5]  = '{1'b1, 3'b000, 1'b0, 3, 2'b11, 0, 0, 0, 0};
    tbl[6]  = '{1'b1, 3'b101, 1'b0, 5, 2'b11, 1, 0, 0, 5};
    tbl[7]  = '{1'b1, 3'b101, 1'b0, 5, 2'b11, 0, 0, 0, 0};
    tbl[8]  = '{1'b1, 3'b101, 1'b1, 20, 2'b11, 0, 0, 0, 0};
    tbl[9]  = '{1'b1, 3'b101, 1'b0, 3, 2'b11, 1, 0, 0, 3};
    tbl[10] = '{1'b1, 3'b101, 1'b0, 7, 2'b11, 0, 0, 0, 0};
    tbl[11] = '{1'b1, 3'b101, 1'b1, 4, 2'b11, 0, 0, 0, 0};
    tbl[12] = '{1'b1, 3'b101, 1'b0, 1, 2'b11, 1, 0, 0, 1};
    tbl[13] = '{1'b1, 3'b101, 1'b0, 2, 2'b11, 0, 0, 0, 0};
    tbl[14] = '{1'b1, 3'b000, 1'b0, 6, 2'b11, 1, 0, 0, 6};
    tbl[15] = '{1'b1, 3'b000, 1'b0, 8, 2'b10, 1, 1, 0, 8};
    tbl[16] = '{1'b1, 3'b111, 1'b0, 8, 2'b10, 1, 0, 1, 8};
    tbl[17] = '{1'b1, 3'b110, 1'b0, 8, 2'b01, 1, 1, 0, 8};
    tbl[18] = '{1'b1, 3'b100, 1'b0, 8, 2'b00, 1, 1, 0, 8};
    tbl[19] = '{1'b1, 3'b000, 1'b0, 8, 2'b00, 1, 0, 1, 8};
    tbl[20] = '{1'b1, 3'b110, 1'b0, 4, 2'b00, 0, 0, 0, 0};
    tbl[21] = '{1'b0, 3'b110, 1'b0, 1, 2'b11, 0, 0, 0, 0};
    tbl[22] = '{1'b1, 3'b110, 1'b0, 8, 2'b11, 1, 0, 1, 8};

    rst = 1'b0; button = 3'b101; pause = 1'b0;

    for (int i = 0; i < NV; i++) begin
      rst    = tbl[i].r;
      button = tbl[i].btn;
      pause  = tbl[i].pse;
      sbq.push_back(tbl[i]);
      run_cycles(tbl[i].n, tbl[i].r, t, c, b, f);
      e = sbq.pop_front();
      check($sformatf("seg%0d_dir", i), int'(dir), int'(e.e_dir));
      check($sformatf("seg%0d_ticks", i), t, e.e_ticks);
      check($sformatf("seg%0d_dir_changed", i), c, e.e_chg);
      check($sformatf("seg%0d_rev_blocked", i), b, e.e_blk);
      check($sformatf("seg%0d_first_tick", i), f, e.e_first);
      if (!tbl[i].r) begin
        check($sformatf("seg%0d_rst_tick", i), int'(tick), 0);
        check($sformatf("seg%0d_rst_dir_changed", i), int'(dir_changed), 0);
        check($sformatf("seg%0d_rst_rev_blocked", i), int'(rev_blocked), 0);
      end
    end

    // Reset taken while paused, then first tick must land TICK_DIV edges
    // after release.
    button = 3'b101;
    pause  = 1'b1;
    run_cycles(3, 1'b1, t, c, b, f);
    check("pause_pre_reset_ticks", t, 0);
    rst = 1'b0;
    run_cycles(1, 1'b0, t, c, b, f);
    check("pause_reset_tick", int'(tick), 0);
    check("pause_reset_dir", int'(dir), 3);
    rst   = 1'b1;
    pause = 1'b0;
    edges = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (tick && edges == 0) edges = k;
    end
    check("post_reset_first_tick_edge", edges, 8);
    check("post_reset_dir", int'(dir), 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
